// File: rtl/instr_encoder.sv
// Encodes ADD/ADDI/BEQ/JAL/JALR requests into RV32I words and writes them to instruction memory.
// One word per two cycles; req_ready only in ACCEPT; sticky done/err end a session until the next start.
module instr_encoder #(
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [20:0] req_imm,
  input  logic        req_last,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [16:0] count,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE, S_ERR} state_t;

  localparam logic [16:0] MEM_WORDS_C = 17'(MEM_WORDS);

  state_t      state_q, state_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [16:0] count_q, count_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        last_q, last_d;

  logic        xfer, op_illegal, imm_bad, mem_full, fits12, fits13;
  logic [31:0] enc_word;

  assign xfer     = req_valid && (state_q == S_ACCEPT);
  assign mem_full = (count_q == MEM_WORDS_C);
  assign fits12   = (req_imm[20:11] == {10{req_imm[11]}});
  assign fits13   = (req_imm[20:12] == {9{req_imm[12]}});

  // Fields an op does not use are simply left out of its encoding and checks.
  always_comb begin
    enc_word   = 32'h0;
    op_illegal = 1'b0;
    imm_bad    = 1'b0;
    case (req_op)
      3'b000: enc_word = {7'b0, req_rs2, req_rs1, 3'b000, req_rd, 7'b0110011};
      3'b001: begin
        enc_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, 7'b0010011};
        imm_bad  = !fits12;
      end
      3'b010: begin
        enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b000,
                    req_imm[4:1], req_imm[11], 7'b1100011};
        imm_bad  = !fits13 || req_imm[0];
      end
      3'b011: begin
        enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                    req_rd, 7'b1101111};
        imm_bad  = req_imm[0];
      end
      3'b100: begin
        enc_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, 7'b1100111};
        imm_bad  = !fits12;
      end
      default: op_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_ACCEPT;
    end else begin
      case (state_q)
        S_ACCEPT: if (xfer) state_d = (op_illegal || mem_full || imm_bad) ? S_ERR : S_WRITE;
        S_WRITE:  state_d = last_q ? S_DONE : S_ACCEPT;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    req_ready = (state_q == S_ACCEPT);
    imem_we   = (state_q == S_WRITE);
  end

  // imem_addr is loaded only at an accepted transfer so it holds between writes;
  // wr_addr tracks the next free location.
  always_comb begin
    imem_addr_d = imem_addr_q;
    wr_addr_d   = wr_addr_q;
    wdata_d     = wdata_q;
    count_d     = count_q;
    done_d      = done_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    last_d      = last_q;
    if (start) begin
      wr_addr_d  = BASE_ADDR;
      count_d    = 17'd0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = 2'b00;
      last_d     = 1'b0;
    end else if (xfer) begin
      if (op_illegal) begin
        err_d      = 1'b1;
        err_code_d = 2'b01;
      end else if (mem_full) begin
        err_d      = 1'b1;
        err_code_d = 2'b11;
      end else if (imm_bad) begin
        err_d      = 1'b1;
        err_code_d = 2'b10;
      end else begin
        wdata_d     = enc_word;
        imem_addr_d = wr_addr_q;
        last_d      = req_last;
      end
    end else if (state_q == S_WRITE) begin
      count_d   = count_q + 17'd1;
      wr_addr_d = wr_addr_q + 32'd4;
      if (last_q) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_addr_q <= BASE_ADDR;
      wr_addr_q   <= BASE_ADDR;
      wdata_q     <= 32'h0;
      count_q     <= 17'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      last_q      <= 1'b0;
    end else begin
      imem_addr_q <= imem_addr_d;
      wr_addr_q   <= wr_addr_d;
      wdata_q     <= wdata_d;
      count_q     <= count_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      last_q      <= last_d;
    end
  end

  assign imem_addr  = imem_addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder (MEM_WORDS=4): directed scenarios plus randomized sessions
// compared against an arithmetic model of the RV32I field layouts and range rules.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [4:0]  req_rd = 5'd0, req_rs1 = 5'd0, req_rs2 = 5'd0;
  logic [20:0] req_imm = 21'd0;
  logic        req_last = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr, imem_wdata;
  logic [16:0] count;
  logic        done, err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_fail = 0;

  instr_encoder #(.MEM_WORDS(4), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_imm(req_imm), .req_last(req_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .count(count), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference encoding built from the instruction-format field positions.
  function automatic logic [31:0] ref_enc(input int op, input int rd, input int rs1, input int rs2, input int imm);
    logic [31:0] u, d, s1, s2;
    u = imm; d = rd; s1 = rs1; s2 = rs2;
    case (op)
      0: return (s2 << 20) | (s1 << 15) | (d << 7) | 32'h33;
      1: return ((u & 32'hFFF) << 20) | (s1 << 15) | (d << 7) | 32'h13;
      2: return (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (s2 << 20) | (s1 << 15)
              | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
      3: return (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20)
              | (((u >> 12) & 255) << 12) | (d << 7) | 32'h6F;
      4: return ((u & 32'hFFF) << 20) | (s1 << 15) | (d << 7) | 32'h67;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_err(input int op, input int imm);
    case (op)
      0: return 0;
      1, 4: return (imm < -2048 || imm > 2047) ? 2 : 0;
      2: return (imm < -4096 || imm > 4094 || (imm % 2) != 0) ? 2 : 0;
      3: return (imm < -1048576 || imm > 1048574 || (imm % 2) != 0) ? 2 : 0;
      default: return 1;
    endcase
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Waits for req_ready, presents one request for one cycle, samples the write port a cycle later.
  task automatic drive_req(input int op, input int rd, input int rs1, input int rs2, input int imm,
                           input bit last, output bit we, output logic [31:0] addr, output logic [31:0] wdata);
    int waited = 0;
    while (req_ready !== 1'b1 && waited < 8) begin
      @(negedge clk); waited++;
    end
    if (req_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout got=%b exp=1", req_ready);
    end
    req_op = 3'(op); req_rd = 5'(rd); req_rs1 = 5'(rs1); req_rs2 = 5'(rs2);
    req_imm = 21'(imm); req_last = last; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_last = 1'b0;
    we = imem_we; addr = imem_addr; wdata = imem_wdata;
  endtask

  task automatic test_reset();
    logic [89:0] got;
    got = {req_ready, imem_we, imem_addr, imem_wdata, count, done, err, err_code};
    n_checks++;
    if (got !== 90'h0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", got); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_ready, imem_we} !== 2'b00) begin n_fail++; $display("FAIL idle_after_reset got=%b exp=00", {req_ready, imem_we}); end
  endtask

  task automatic test_addi();
    bit we; logic [31:0] a, w;
    pulse_start();
    n_checks++;
    if ({req_ready, count, done, err} !== {1'b1, 17'd0, 2'b00}) begin n_fail++; $display("FAIL start_state got=%b/%0d/%b/%b exp=1/0/0/0", req_ready, count, done, err); end
    drive_req(1, 1, 0, 0, 5, 1'b1, we, a, w);
    n_checks++;
    if ({we, a, w} !== {1'b1, 32'h0, 32'h00500093}) begin n_fail++; $display("FAIL addi_write got=%b %h %h exp=1 0 00500093", we, a, w); end
    @(negedge clk);
    n_checks++;
    if ({done, count, imem_we, req_ready} !== {1'b1, 17'd1, 2'b00}) begin n_fail++; $display("FAIL addi_done got=%b/%0d/%b/%b exp=1/1/0/0", done, count, imem_we, req_ready); end
  endtask

  task automatic test_add_beq();
    bit we; logic [31:0] a, w;
    pulse_start();
    drive_req(0, 3, 1, 2, 12345, 1'b0, we, a, w);
    n_checks++;
    if ({we, a, w} !== {1'b1, 32'h0, 32'h002081B3}) begin n_fail++; $display("FAIL add_write got=%b %h %h exp=1 0 002081b3", we, a, w); end
    drive_req(2, 31, 1, 2, -8, 1'b1, we, a, w);
    n_checks++;
    if ({we, a, w} !== {1'b1, 32'h4, 32'hFE208CE3}) begin n_fail++; $display("FAIL beq_write got=%b %h %h exp=1 4 fe208ce3", we, a, w); end
    @(negedge clk);
    n_checks++;
    if ({done, count} !== {1'b1, 17'd2}) begin n_fail++; $display("FAIL add_beq_done got=%b/%0d exp=1/2", done, count); end
  endtask

  task automatic test_jal_jalr();
    bit we; logic [31:0] a, w;
    pulse_start();
    drive_req(3, 1, 0, 0, 2048, 1'b0, we, a, w);
    n_checks++;
    if ({we, a, w} !== {1'b1, 32'h0, 32'h001000EF}) begin n_fail++; $display("FAIL jal_write got=%b %h %h exp=1 0 001000ef", we, a, w); end
    drive_req(4, 0, 1, 0, 0, 1'b0, we, a, w);
    n_checks++;
    if ({we, a, w} !== {1'b1, 32'h4, 32'h00008067}) begin n_fail++; $display("FAIL jalr_write got=%b %h %h exp=1 4 00008067", we, a, w); end
    drive_req(3, 1, 0, 0, 3, 1'b0, we, a, w);
    n_checks++;
    if ({we, err, err_code, count, a} !== {1'b0, 1'b1, 2'b10, 17'd2, 32'h4}) begin n_fail++; $display("FAIL jal_misaligned got=%b/%b/%b/%0d/%h exp=0/1/10/2/4", we, err, err_code, count, a); end
  endtask

  task automatic test_illegal();
    bit we; logic [31:0] a, w;
    pulse_start();
    drive_req(7, 1, 1, 1, 0, 1'b1, we, a, w);
    @(negedge clk);
    n_checks++;
    if ({we, imem_we, err, err_code, req_ready} !== {2'b00, 1'b1, 2'b01, 1'b0}) begin n_fail++; $display("FAIL illegal_op got=%b/%b/%b/%b/%b exp=0/0/1/01/0", we, imem_we, err, err_code, req_ready); end
    pulse_start();
    n_checks++;
    if ({err, err_code, req_ready} !== {1'b0, 2'b00, 1'b1}) begin n_fail++; $display("FAIL restart_clears got=%b/%b/%b exp=0/00/1", err, err_code, req_ready); end
  endtask

  task automatic test_overflow();
    bit we; logic [31:0] a, w;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      drive_req(0, i + 1, i, 2 * i, 0, 1'b0, we, a, w);
      n_checks++;
      if ({we, a, w} !== {1'b1, 32'(4 * i), ref_enc(0, i + 1, i, 2 * i, 0)}) begin n_fail++; $display("FAIL fill_write%0d got=%b %h %h exp=1 %h %h", i, we, a, w, 32'(4 * i), ref_enc(0, i + 1, i, 2 * i, 0)); end
    end
    drive_req(0, 5, 5, 5, 0, 1'b0, we, a, w);
    n_checks++;
    if ({we, err, err_code, count} !== {1'b0, 1'b1, 2'b11, 17'd4}) begin n_fail++; $display("FAIL overflow got=%b/%b/%b/%0d exp=0/1/11/4", we, err, err_code, count); end
  endtask

  task automatic test_reset_mid_write();
    bit we; logic [31:0] a, w;
    logic [89:0] got;
    pulse_start();
    drive_req(1, 2, 3, 0, -1, 1'b0, we, a, w);
    n_checks++;
    if (we !== 1'b1) begin n_fail++; $display("FAIL pre_reset_write got=%b exp=1", we); end
    rst_n = 1'b0;
    #1;
    got = {req_ready, imem_we, imem_addr, imem_wdata, count, done, err, err_code};
    n_checks++;
    if (got !== 90'h0) begin n_fail++; $display("FAIL mid_write_reset got=%h exp=0", got); end
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({req_ready, imem_we, count} !== 19'd0) begin n_fail++; $display("FAIL idle_until_start got=%b/%b/%0d exp=0/0/0", req_ready, imem_we, count); end
    pulse_start();
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_start got=%b exp=1", req_ready); end
  endtask

  task automatic test_random_sessions();
    bit we; logic [31:0] a, w;
    for (int s = 0; s < 24; s++) begin
      int len, written, e;
      len = $urandom_range(1, 4);
      written = 0; e = 0;
      pulse_start();
      for (int k = 0; k < len; k++) begin
        int op, rd, rs1, rs2, imm, sel;
        logic [31:0] r;
        op  = ($urandom_range(0, 11) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
        rd  = $urandom_range(0, 31); rs1 = $urandom_range(0, 31); rs2 = $urandom_range(0, 31);
        sel = $urandom_range(0, 3);
        r   = $urandom;
        if (sel == 0)      imm = $urandom_range(0, 4095) - 2048;
        else if (sel == 1) imm = 2 * ($urandom_range(0, 4095) - 2048);
        else               imm = int'(r[20:0]) - ((r[20]) ? 2097152 : 0);
        e = ref_err(op, imm);
        drive_req(op, rd, rs1, rs2, imm, k == len - 1, we, a, w);
        if (e != 0) begin
          n_checks++;
          if ({we, err, err_code, count} !== {1'b0, 1'b1, 2'(e), 17'(written)}) begin n_fail++; $display("FAIL rand_err s%0d op=%0d imm=%0d got=%b/%b/%b/%0d exp=0/1/%0d/%0d", s, op, imm, we, err, err_code, count, e, written); end
          break;
        end
        n_checks++;
        if ({we, a, w} !== {1'b1, 32'(4 * written), ref_enc(op, rd, rs1, rs2, imm)}) begin n_fail++; $display("FAIL rand_write s%0d op=%0d imm=%0d got=%b %h %h exp=1 %h %h", s, op, imm, we, a, w, 32'(4 * written), ref_enc(op, rd, rs1, rs2, imm)); end
        written++;
      end
      if (e == 0) begin
        @(negedge clk);
        n_checks++;
        if ({done, err, count} !== {1'b1, 1'b0, 17'(written)}) begin n_fail++; $display("FAIL rand_done s%0d got=%b/%b/%0d exp=1/0/%0d", s, done, err, count, written); end
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_addi();
    test_add_beq();
    test_jal_jalr();
    test_illegal();
    test_overflow();
    test_reset_mid_write();
    test_random_sessions();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: MEM_WORDS, 256, instruction-memory capacity in 32-bit words (power of two, 2..65536).
REQ-002 Parameter: BASE_ADDR, 32'h0000_0000, byte address of the first word written.
REQ-003 Port: clk  in  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: start  in  1  one-cycle pulse; begins a new load session.
REQ-006 Port: req_valid  in  1  request present.
REQ-007 Port: req_ready  out  1  encoder can accept a request.
REQ-008 Port: req_op  in  3  000 ADD, 001 ADDI, 010 BEQ, 011 JAL, 100 JALR; 101-111 illegal.
REQ-009 Port: req_rd / req_rs1 / req_rs2  in  5 each  register indices.
REQ-010 Port: req_imm  in  21  signed two's-complement immediate or byte offset.
REQ-011 Port: req_last  in  1  marks the final request of the session.
REQ-012 Port: imem_we  out  1  instruction-memory write strobe.
REQ-013 Port: imem_addr  out  32  byte address of the write.
REQ-014 Port: imem_wdata  out  32  encoded RV32I instruction word.
REQ-015 Port: count  out  17  number of words written this session.
REQ-016 Port: done  out  1  session completed normally (sticky).
REQ-017 Port: err  out  1  session aborted (sticky).
REQ-018 Port: err_code  out  2  01 illegal op, 10 immediate out of range or misaligned, 11 memory overflow.

Function
REQ-019 FSM states IDLE, ACCEPT, WRITE, DONE, ERR; start from any state except during reset goes to ACCEPT, clears count, done, err, err_code, sets address to BASE_ADDR.
REQ-020 req_ready SHALL be 1 only in ACCEPT; a transfer occurs on a cycle with req_valid=1 and req_ready=1; start has priority over a simultaneous transfer (transfer discarded).
REQ-021 On a valid transfer, the word SHALL be registered into imem_wdata and the FSM SHALL enter WRITE; imem_we=1 for exactly one cycle in WRITE (one cycle after the transfer); throughput one word per two cycles.
REQ-022 Encodings, bit fields MSB first: ADD = 0000000|rs2|rs1|000|rd|0110011; ADDI = imm[11:0]|rs1|000|rd|0010011; BEQ = imm[12]|imm[10:5]|rs2|rs1|000|imm[4:1]|imm[11]|1100011; JAL = imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111; JALR = imm[11:0]|rs1|000|rd|1100111.
REQ-023 Fields unused by an op (rs2 for ADDI/JAL/JALR, rd for BEQ, imm for ADD) SHALL be ignored and never cause an error.
REQ-024 Range checks: ADDI/JALR -2048..2047; BEQ -4096..4094 and even; JAL -1048576..1048574 and even; violation -> err_code 10.
REQ-025 Illegal op -> err_code 01; the error SHALL be detected at transfer, no write issued, FSM to ERR, err=1.
REQ-026 After each write, imem_addr SHALL advance by 4 and count by 1 (from WRITE back to ACCEPT), or to DONE with done=1 if req_last was set on that request.
REQ-027 A transfer when count == MEM_WORDS (memory full, req_last not yet seen) SHALL write nothing, go to ERR with err_code 11.
REQ-028 In IDLE, DONE, ERR: req_ready=0, imem_we=0; only start leaves these states.
REQ-029 imem_addr and imem_wdata SHALL hold their last values when imem_we=0.

Reset
REQ-030 While rst_n=0, asynchronously: state IDLE, req_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, done=0, err=0, err_code=00.
REQ-031 Reset asserted mid-session (including during WRITE) SHALL abort immediately with no further write; first cycle after release is IDLE.

Verification
REQ-032 start; ADDI rd=1 rs1=0 imm=5, last=1 -> one cycle later imem_we=1, addr 0x0, wdata 0x00500093; then done=1, count=1.
REQ-033 ADD rd=3 rs1=1 rs2=2, then BEQ rs1=1 rs2=2 imm=-8 last=1 -> wdata 0x002081B3 at 0x0, 0xFE208CE3 at 0x4, count=2.
REQ-034 JAL rd=1 imm=2048 -> 0x001000EF; JALR rd=0 rs1=1 imm=0 -> 0x00008067; JAL imm=3 -> no write, err=1, err_code 10.
REQ-035 req_op=111 -> no imem_we, err_code 01; subsequent start clears err, req_ready=1 next cycle.
REQ-036 MEM_WORDS=4, five requests without last -> four writes at 0x0..0xC, fifth gives err_code 11, count=4.
REQ-037 rst_n low during WRITE cycle -> imem_we drops immediately, all outputs at reset values, req_ready=0 until start.
